// File: rtl/request_queue.sv
// request_queue: FIFO of {opcode, addr} requests feeding the SPI serializer,
// with retry-on-error and drop after MAX_RETRY re-offers.
module request_queue #(
  parameter int ADDRW     = 8,
  parameter int OPCODEW   = 2,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [OPCODEW-1:0]         push_opcode,
  input  logic [ADDRW-1:0]           push_addr,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       valid_out,
  output logic [OPCODEW-1:0]         opcode_out,
  output logic [ADDRW-1:0]           addr_out,
  input  logic                       ready_in,
  input  logic                       err_in,
  output logic                       done,
  output logic                       drop
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY+1) : 1;
  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;
  state_t state, state_n;
  logic [OPCODEW+ADDRW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [RW-1:0] retry_cnt;
  logic accept, fin, retry, pop;
  logic [CW-1:0] count_n;
  // fin marks the serializer returning to idle; err_in is judged in that same cycle
  always_comb begin
    accept  = push && !full;
    fin     = state == BUSY && ready_in;
    retry   = fin && err_in && retry_cnt < RW'(MAX_RETRY);
    pop     = fin && !retry;
    count_n = count + CW'(accept) - CW'(pop);
    state_n = state == IDLE  ? (count_n != '0 ? OFFER : IDLE) :
              state == OFFER ? (ready_in ? OFFER : BUSY) :
              fin            ? (retry || count_n != '0 ? OFFER : IDLE) : BUSY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      full      <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      drop      <= 1'b0;
      retry_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      state     <= state_n;
      valid_out <= state_n == OFFER;
      count     <= count_n;
      full      <= count_n == CW'(DEPTH);
      overflow  <= push && full;
      done      <= pop && !err_in;
      drop      <= pop && err_in;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (fin) retry_cnt <= retry ? retry_cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk) if (accept) mem[wr_ptr] <= {push_opcode, push_addr};
  assign {opcode_out, addr_out} = mem[rd_ptr];
endmodule

// File: tb/tb_request_queue.sv
// tb_request_queue: directed self-checking bench for request_queue.
module tb_request_queue;
  logic clk = 1'b0, rst_n = 1'b0, push = 1'b0, ready_in = 1'b1, err_in = 1'b0;
  logic [1:0] push_opcode = '0, opcode_out;
  logic [7:0] push_addr = '0, addr_out;
  logic full, overflow, valid_out, done, drop;
  logic [2:0] count;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  request_queue dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_opcode(push_opcode), .push_addr(push_addr),
    .full(full), .count(count), .overflow(overflow), .valid_out(valid_out),
    .opcode_out(opcode_out), .addr_out(addr_out), .ready_in(ready_in), .err_in(err_in),
    .done(done), .drop(drop)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push_one(input logic [1:0] op, input logic [7:0] a);
    push = 1'b1;
    push_opcode = op;
    push_addr = a;
    tick();
    push = 1'b0;
  endtask
  // serializer model: load (ready low) then return ready with the given err
  task automatic send(input logic e);
    ready_in = 1'b0;
    tick();
    chk("busy_valid_low", valid_out, 0);
    ready_in = 1'b1;
    err_in = e;
    tick();
    err_in = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;
    tick();
    // 1: single request, clean send
    push_one(2'b10, 8'hA5);
    chk("t1_valid", valid_out, 1);
    chk("t1_addr", addr_out, 8'hA5);
    chk("t1_op", opcode_out, 2'b10);
    chk("t1_count", count, 1);
    tick();
    tick();
    chk("t1_hold_valid", valid_out, 1);
    ready_in = 1'b0;
    tick();
    chk("t1_busy_valid", valid_out, 0);
    tick();
    tick();
    chk("t1_wait_valid", valid_out, 0);
    chk("t1_wait_done", done, 0);
    ready_in = 1'b1;
    tick();
    chk("t1_done", done, 1);
    chk("t1_count0", count, 0);
    chk("t1_valid_idle", valid_out, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", valid_out, 0);
    // 2: fill, overflow, drain in order
    for (int i = 0; i < 4; i++) push_one(2'(i), 8'h10 + 8'(i));
    chk("t2_full", full, 1);
    chk("t2_count", count, 4);
    push_one(2'b11, 8'hEE);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_after", count, 4);
    tick();
    chk("t2_ovf_pulse", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", valid_out, 1);
      chk("t2_addr", addr_out, 8'h10 + i);
      chk("t2_op", opcode_out, i);
      send(1'b0);
      chk("t2_done", done, 1);
      chk("t2_count_dec", count, 3 - i);
    end
    chk("t2_full_clr", full, 0);
    chk("t2_idle", valid_out, 0);
    // 3: two errors, then clean
    push_one(2'b01, 8'h33);
    for (int i = 0; i < 2; i++) begin
      send(1'b1);
      chk("t3_no_done", done, 0);
      chk("t3_no_drop", drop, 0);
      chk("t3_reoffer", valid_out, 1);
      chk("t3_addr", addr_out, 8'h33);
      chk("t3_op", opcode_out, 2'b01);
      chk("t3_count", count, 1);
    end
    send(1'b0);
    chk("t3_done", done, 1);
    chk("t3_drop", drop, 0);
    chk("t3_count0", count, 0);
    chk("t3_retry_clr", dut.retry_cnt, 0);
    // 4: three errors -> drop, next entry offered
    push_one(2'b11, 8'h44);
    push_one(2'b00, 8'h55);
    chk("t4_count", count, 2);
    send(1'b1);
    send(1'b1);
    chk("t4_addr_kept", addr_out, 8'h44);
    chk("t4_no_drop", drop, 0);
    send(1'b1);
    chk("t4_drop", drop, 1);
    chk("t4_no_done", done, 0);
    chk("t4_count", count, 1);
    chk("t4_next_valid", valid_out, 1);
    chk("t4_next_addr", addr_out, 8'h55);
    chk("t4_next_op", opcode_out, 2'b00);
    tick();
    chk("t4_drop_pulse", drop, 0);
    send(1'b0);
    chk("t4_done", done, 1);
    chk("t4_count0", count, 0);
    // 5: push while full in the same cycle as a clean pop
    for (int i = 0; i < 4; i++) push_one(2'b01, 8'hE0 + 8'(i));
    chk("t5_full", full, 1);
    ready_in = 1'b0;
    tick();
    ready_in = 1'b1;
    push = 1'b1;
    push_addr = 8'h99;
    tick();
    push = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_ovf", overflow, 1);
    chk("t5_count", count, 3);
    for (int i = 1; i < 4; i++) begin
      chk("t5_addr", addr_out, 8'hE0 + i);
      send(1'b0);
    end
    chk("t5_count0", count, 0);
    chk("t5_idle", valid_out, 0);
    // 6: async reset while busy
    for (int i = 0; i < 3; i++) push_one(2'b10, 8'h60 + 8'(i));
    ready_in = 1'b0;
    tick();
    chk("t6_busy_count", count, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", valid_out, 0);
    chk("t6_rst_full", full, 0);
    @(negedge clk);
    ready_in = 1'b1;
    rst_n = 1'b1;
    tick();
    push_one(2'b01, 8'h77);
    chk("t6_valid", valid_out, 1);
    chk("t6_addr", addr_out, 8'h77);
    chk("t6_count", count, 1);
    send(1'b0);
    chk("t6_done", done, 1);
    chk("t6_count0", count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
